// File: rtl/ifetch_pkg.sv
// Shared 6502 front-end definitions: widths, fetch FSM states, instruction lengths.
package ifetch_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 2;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0200;

  localparam logic [LEN_W-1:0] LEN1 = 2'd1;
  localparam logic [LEN_W-1:0] LEN2 = 2'd2;
  localparam logic [LEN_W-1:0] LEN3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    HOLD
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_ins_length.sv
// Opcode to instruction length (1..3 bytes); shared by fetch and execute.
module ifetch_ins_length
  import ifetch_pkg::*;
(
  input  logic [DATA_W-1:0] opcode,
  output logic [LEN_W-1:0]  len_c
);

  logic one_c;
  logic three_c;

  // Single-byte rules take precedence over three-byte rules; everything else is two bytes.
  always_comb begin
    len_c   = LEN2;
    one_c   = (opcode == 8'h00) || (opcode == 8'h40) || (opcode == 8'h60)
           || (!opcode[7] && (opcode[4:0] == 5'b00010))
           || ((opcode[3:2] == 2'b10) && !opcode[0]);
    three_c = (opcode == 8'h20)
           || (opcode[4:2] == 3'b011)
           || ((opcode[4:2] == 3'b110) && opcode[0])
           || (opcode[4:2] == 3'b111);
    if (one_c) begin
      len_c = LEN1;
    end else if (three_c) begin
      len_c = LEN3;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch sequencer: reads opcode/operand bytes at the fetch PC and
// presents a complete instruction bundle over a valid/ready handshake.
// Optional macro IFETCH_PREFETCH_EN: prefetch the next opcode byte while holding a bundle.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_opcode,
  output logic [ADDR_W-1:0] ins_operand,
  output logic [LEN_W-1:0]  ins_len,
  output logic [ADDR_W-1:0] ins_pc
);

  ifetch_state_t     state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              mem_rd_nxt;
  logic              ins_valid_nxt;
  logic [DATA_W-1:0] opcode_nxt;
  logic [ADDR_W-1:0] operand_nxt;
  logic [LEN_W-1:0]  len_nxt;
  logic [ADDR_W-1:0] ins_pc_nxt;
  logic              xfer_c;
  logic              accept_c;
  logic [DATA_W-1:0] op_sel_c;
  logic [LEN_W-1:0]  op_len_c;

`ifdef IFETCH_PREFETCH_EN
  logic              pf_valid, pf_valid_nxt;
  logic [DATA_W-1:0] pf_byte, pf_byte_nxt;
`endif

  assign mem_addr = pc;
  assign xfer_c   = mem_rd && mem_ready;
  assign accept_c = ins_valid && ins_ready;

  // A held prefetch byte, when present, is the next opcode; otherwise the bus byte is.
`ifdef IFETCH_PREFETCH_EN
  assign op_sel_c = pf_valid ? pf_byte : mem_rdata;
`else
  assign op_sel_c = mem_rdata;
`endif

  ifetch_ins_length u_ins_length (
    .opcode (op_sel_c),
    .len_c  (op_len_c)
  );

  // Next-state, next-PC and bundle capture; pc_load overrides everything.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    opcode_nxt  = ins_opcode;
    operand_nxt = ins_operand;
    len_nxt     = ins_len;
    ins_pc_nxt  = ins_pc;
`ifdef IFETCH_PREFETCH_EN
    pf_valid_nxt = pf_valid;
    pf_byte_nxt  = pf_byte;
`endif
    case (state)
      IDLE: state_nxt = FETCH_OP;
      FETCH_OP: begin
        if (xfer_c) begin
          opcode_nxt  = mem_rdata;
          ins_pc_nxt  = pc;
          operand_nxt = '0;
          len_nxt     = op_len_c;
          pc_nxt      = ADDR_W'(pc + 16'd1);
          state_nxt   = (op_len_c == LEN1) ? HOLD : FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (xfer_c) begin
          operand_nxt[DATA_W-1:0] = mem_rdata;
          pc_nxt                  = ADDR_W'(pc + 16'd1);
          state_nxt               = (ins_len == LEN2) ? HOLD : FETCH_HI;
        end
      end
      FETCH_HI: begin
        if (xfer_c) begin
          operand_nxt[ADDR_W-1:DATA_W] = mem_rdata;
          pc_nxt                       = ADDR_W'(pc + 16'd1);
          state_nxt                    = HOLD;
        end
      end
      HOLD: begin
`ifdef IFETCH_PREFETCH_EN
        if (accept_c && (pf_valid || xfer_c)) begin
          opcode_nxt   = op_sel_c;
          ins_pc_nxt   = pf_valid ? ADDR_W'(pc - 16'd1) : pc;
          operand_nxt  = '0;
          len_nxt      = op_len_c;
          pf_valid_nxt = 1'b0;
          if (xfer_c) begin
            pc_nxt = ADDR_W'(pc + 16'd1);
          end
          state_nxt = (op_len_c == LEN1) ? HOLD : FETCH_LO;
        end else if (accept_c) begin
          state_nxt = FETCH_OP;
        end else if (xfer_c) begin
          pf_valid_nxt = 1'b1;
          pf_byte_nxt  = mem_rdata;
          pc_nxt       = ADDR_W'(pc + 16'd1);
        end
`else
        if (accept_c) begin
          state_nxt = FETCH_OP;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase

    if (pc_load) begin
      state_nxt   = FETCH_OP;
      pc_nxt      = pc_load_addr;
      opcode_nxt  = ins_opcode;
      operand_nxt = ins_operand;
      len_nxt     = ins_len;
      ins_pc_nxt  = ins_pc;
`ifdef IFETCH_PREFETCH_EN
      pf_valid_nxt = 1'b0;
      pf_byte_nxt  = pf_byte;
`endif
    end

    ins_valid_nxt = (state_nxt == HOLD);
    mem_rd_nxt    = (state_nxt == FETCH_OP) || (state_nxt == FETCH_LO) || (state_nxt == FETCH_HI);
`ifdef IFETCH_PREFETCH_EN
    mem_rd_nxt    = mem_rd_nxt || ((state_nxt == HOLD) && !pf_valid_nxt);
`endif
  end

  // State, PC and registered bundle/bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_rd      <= 1'b0;
      ins_valid   <= 1'b0;
      ins_opcode  <= '0;
      ins_operand <= '0;
      ins_len     <= LEN1;
      ins_pc      <= '0;
`ifdef IFETCH_PREFETCH_EN
      pf_valid    <= 1'b0;
      pf_byte     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      mem_rd      <= mem_rd_nxt;
      ins_valid   <= ins_valid_nxt;
      ins_opcode  <= opcode_nxt;
      ins_operand <= operand_nxt;
      ins_len     <= len_nxt;
      ins_pc      <= ins_pc_nxt;
`ifdef IFETCH_PREFETCH_EN
      pf_valid    <= pf_valid_nxt;
      pf_byte     <= pf_byte_nxt;
`endif
    end
  end

endmodule
